// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, instruction field positions and
// the fetch sequencer state encoding.
package proc_pkg;

    localparam int unsigned PROC_ADDR_W = 4;
    localparam int unsigned PROC_INST_W = 16;
    localparam int unsigned PROC_CNT_W  = 16;
    localparam int unsigned OPC_W       = 4;

    // Instruction field positions
    localparam int unsigned OP_HI  = 15;
    localparam int unsigned OP_LO  = 12;
    localparam int unsigned TGT_HI = 11;
    localparam int unsigned TGT_LO = 8;

    localparam logic [OPC_W-1:0] OPC_NOP  = 4'b0000;
    localparam logic [OPC_W-1:0] OPC_LOAD = 4'b0001;
    localparam logic [OPC_W-1:0] OPC_ADD  = 4'b0010;
    localparam logic [OPC_W-1:0] OPC_SUB  = 4'b0011;
    localparam logic [OPC_W-1:0] OPC_JMP  = 4'b1000;
    localparam logic [OPC_W-1:0] OPC_SUBI = 4'b1011;
    localparam logic [OPC_W-1:0] OPC_BR   = 4'b1100;
    localparam logic [OPC_W-1:0] OPC_MOV  = 4'b1110;
    localparam logic [OPC_W-1:0] OPC_OUT  = 4'b1111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM read port plus the instruction-issue handshake towards the datapath.
// master = sequencer side, slave = ROM/datapath side.
interface fetch_sequencer_if
    import proc_pkg::*;
#(
    parameter int unsigned ADDR_W = PROC_ADDR_W,
    parameter int unsigned INST_W = PROC_INST_W
) ();

    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic [INST_W-1:0] ir;
    logic              exec_valid;
    logic              exec_ready;
    logic              zero_flag;

    modport master (
        output rom_addr,
        output ir,
        output exec_valid,
        input  rom_inst,
        input  exec_ready,
        input  zero_flag
    );

    modport slave (
        input  rom_addr,
        input  ir,
        input  exec_valid,
        output rom_inst,
        output exec_ready,
        output zero_flag
    );

endinterface

// File: rtl/fetch_sequencer_pc_unit.sv
// Program counter register: load has priority over increment, increment
// wraps naturally at 2^ADDR_W.
module pc_unit
    import proc_pkg::*;
#(
    parameter int unsigned ADDR_W = PROC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode control: owns the PC, latches instructions, resolves jmp/br/nop
// locally and hands everything else to the datapath over valid/ready.
module fetch_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned ADDR_W = PROC_ADDR_W,
    parameter int unsigned INST_W = PROC_INST_W,
    parameter int unsigned CNT_W  = PROC_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    fetch_sequencer_if.master   bus,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    state_t            state;
    state_t            state_nxt;

    logic [INST_W-1:0] ir_q;
    logic              exec_valid_q;

    logic              ir_load;
    logic              pc_load;
    logic              pc_inc;
    logic              retire;
    logic              set_valid;
    logic              clr_valid;
    logic              set_halt;

    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] target;

    assign opcode = ir_q[OP_HI:OP_LO];
    assign target = ADDR_W'(ir_q[TGT_HI:TGT_LO]);

    assign bus.rom_addr   = pc;
    assign bus.ir         = ir_q;
    assign bus.exec_valid = exec_valid_q;

    pc_unit #(
        .ADDR_W (ADDR_W)
    ) u_pc_unit (
        .clk    (clk),
        .rst    (rst),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (target),
        .pc     (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        retire    = 1'b0;
        set_valid = 1'b0;
        clr_valid = 1'b0;
        set_halt  = 1'b0;

        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = FETCH;
                end
            end

            FETCH: begin
                if (!run) begin
                    state_nxt = IDLE;
                end else begin
                    ir_load   = 1'b1;
                    state_nxt = DECODE;
                end
            end

            DECODE: begin
                case (opcode)
                    OPC_JMP: begin
                        retire = 1'b1;
                        if (target == pc) begin
                            // Jump to own address is the halt idiom
                            set_halt  = 1'b1;
                            state_nxt = HALT;
                        end else begin
                            pc_load   = 1'b1;
                            state_nxt = FETCH;
                        end
                    end
                    OPC_BR: begin
                        retire    = 1'b1;
                        pc_load   = bus.zero_flag;
                        pc_inc    = !bus.zero_flag;
                        state_nxt = FETCH;
                    end
                    OPC_NOP: begin
                        retire    = 1'b1;
                        pc_inc    = 1'b1;
                        state_nxt = FETCH;
                    end
                    default: begin
                        set_valid = 1'b1;
                        state_nxt = EXEC;
                    end
                endcase
            end

            EXEC: begin
                if (bus.exec_ready) begin
                    retire    = 1'b1;
                    pc_inc    = 1'b1;
                    clr_valid = 1'b1;
                    state_nxt = FETCH;
                end
            end

            HALT: begin
                state_nxt = HALT;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Instruction register, handshake valid, halt flag and saturating retire count
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q         <= '0;
            exec_valid_q <= 1'b0;
            halted       <= 1'b0;
            retired      <= '0;
        end else begin
            if (ir_load) begin
                ir_q <= bus.rom_inst;
            end
            if (set_valid) begin
                exec_valid_q <= 1'b1;
            end else if (clr_valid) begin
                exec_valid_q <= 1'b0;
            end
            if (set_halt) begin
                halted <= 1'b1;
            end
            if (retire && (retired != {CNT_W{1'b1}})) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a random program run
// checked against an instruction-level model of the sequencer.
module tb_fetch_sequencer;
    import proc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  pc;
    logic        halted;
    logic [15:0] retired;
    logic [15:0] rom [16];

    int errors = 0;
    int checks = 0;

    fetch_sequencer_if bus ();

    assign bus.rom_inst = rom[bus.rom_addr];

    fetch_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .bus     (bus),
        .pc      (pc),
        .halted  (halted),
        .retired (retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        run            = 1'b0;
        bus.exec_ready = 1'b0;
        bus.zero_flag  = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    task automatic rand_rom();
        logic [3:0] op;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 5))
                0:       op = 4'h8;
                1:       op = 4'hC;
                2:       op = 4'h0;
                default: op = 4'($urandom);
            endcase
            rom[i] = {op, 4'($urandom), 8'($urandom)};
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v == 65535) ? v : v + 1;
    endfunction

    task automatic test_reset();
        rand_rom();
        rst = 1'b1;
        run = 1'b1;
        bus.exec_ready = 1'b1;
        bus.zero_flag  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({pc, halted, retired, bus.ir, bus.exec_valid, bus.rom_addr} !==
                {4'h0, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0}) begin
                errors++;
                $display("FAIL reset_state: got %h want %h",
                         {pc, halted, retired, bus.ir, bus.exec_valid, bus.rom_addr},
                         {4'h0, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        fill_nop();
        rom[0] = 16'h1E07;
        do_reset();
        run = 1'b1;
        bus.exec_ready = 1'b1;
        step();
        checks++;
        if (bus.rom_addr !== 4'h0) begin
            errors++;
            $display("FAIL ff_rom_addr: got %h want %h", bus.rom_addr, 4'h0);
        end
        step();
        checks++;
        if ({bus.ir, bus.exec_valid} !== {16'h1E07, 1'b0}) begin
            errors++;
            $display("FAIL ff_latch: got %h want %h", {bus.ir, bus.exec_valid}, {16'h1E07, 1'b0});
        end
        step();
        checks++;
        if ({bus.exec_valid, bus.ir, pc} !== {1'b1, 16'h1E07, 4'h0}) begin
            errors++;
            $display("FAIL ff_issue: got %h want %h", {bus.exec_valid, bus.ir, pc}, {1'b1, 16'h1E07, 4'h0});
        end
        step();
        checks++;
        if ({bus.exec_valid, pc, retired} !== {1'b0, 4'h1, 16'h1}) begin
            errors++;
            $display("FAIL ff_retire: got %h want %h", {bus.exec_valid, pc, retired}, {1'b0, 4'h1, 16'h1});
        end
    endtask

    task automatic test_halt();
        fill_nop();
        rom[3] = 16'h8300;
        do_reset();
        run = 1'b1;
        repeat (7) step();
        checks++;
        if ({pc, retired, halted} !== {4'h3, 16'h3, 1'b0}) begin
            errors++;
            $display("FAIL halt_approach: got %h want %h", {pc, retired, halted}, {4'h3, 16'h3, 1'b0});
        end
        step();
        step();
        checks++;
        if ({halted, pc, retired} !== {1'b1, 4'h3, 16'h4}) begin
            errors++;
            $display("FAIL halt_detect: got %h want %h", {halted, pc, retired}, {1'b1, 4'h3, 16'h4});
        end
        for (int i = 0; i < 20; i++) begin
            run            = 1'($urandom);
            bus.exec_ready = 1'($urandom);
            bus.zero_flag  = 1'($urandom);
            step();
            checks++;
            if ({halted, pc, bus.exec_valid, retired, bus.ir} !==
                {1'b1, 4'h3, 1'b0, 16'h4, 16'h8300}) begin
                errors++;
                $display("FAIL halt_hold: got %h want %h",
                         {halted, pc, bus.exec_valid, retired, bus.ir},
                         {1'b1, 4'h3, 1'b0, 16'h4, 16'h8300});
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({halted, pc} !== {1'b0, 4'h0}) begin
            errors++;
            $display("FAIL halt_clear: got %h want %h", {halted, pc}, {1'b0, 4'h0});
        end
    endtask

    task automatic test_branch();
        for (int z = 0; z < 2; z++) begin
            fill_nop();
            rom[4] = 16'hCA00;
            do_reset();
            run = 1'b1;
            repeat (9) step();
            checks++;
            if ({pc, retired} !== {4'h4, 16'h4}) begin
                errors++;
                $display("FAIL br_approach: got %h want %h", {pc, retired}, {4'h4, 16'h4});
            end
            step();
            bus.zero_flag = 1'(z);
            step();
            checks++;
            if ({pc, retired, bus.exec_valid, halted} !==
                {((z == 1) ? 4'hA : 4'h5), 16'h5, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL br_taken_z%0d: got %h want %h", z,
                         {pc, retired, bus.exec_valid, halted},
                         {((z == 1) ? 4'hA : 4'h5), 16'h5, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_backpressure();
        int highs;
        fill_nop();
        rom[0] = 16'h2123;
        do_reset();
        run = 1'b1;
        repeat (3) step();
        highs = int'(bus.exec_valid);
        for (int i = 0; i < 5; i++) begin
            step();
            highs += int'(bus.exec_valid);
            checks++;
            if ({bus.ir, pc, retired} !== {16'h2123, 4'h0, 16'h0}) begin
                errors++;
                $display("FAIL bp_stable: got %h want %h", {bus.ir, pc, retired}, {16'h2123, 4'h0, 16'h0});
            end
        end
        bus.exec_ready = 1'b1;
        step();
        bus.exec_ready = 1'b0;
        checks++;
        if (highs !== 6) begin
            errors++;
            $display("FAIL bp_valid_cycles: got %0d want %0d", highs, 6);
        end
        checks++;
        if ({bus.exec_valid, pc, retired} !== {1'b0, 4'h1, 16'h1}) begin
            errors++;
            $display("FAIL bp_release: got %h want %h", {bus.exec_valid, pc, retired}, {1'b0, 4'h1, 16'h1});
        end
        step();
        step();
        checks++;
        if (pc !== 4'h2) begin
            errors++;
            $display("FAIL bp_single_inc: got %h want %h", pc, 4'h2);
        end
    endtask

    task automatic test_wrap_pause();
        fill_nop();
        do_reset();
        run = 1'b1;
        repeat (31) step();
        checks++;
        if ({pc, retired} !== {4'hF, 16'd15}) begin
            errors++;
            $display("FAIL wrap_approach: got %h want %h", {pc, retired}, {4'hF, 16'd15});
        end
        step();
        step();
        checks++;
        if ({pc, retired} !== {4'h0, 16'd16}) begin
            errors++;
            $display("FAIL wrap_pc: got %h want %h", {pc, retired}, {4'h0, 16'd16});
        end
        rom[0] = 16'h3456;
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({bus.ir, pc, bus.exec_valid, retired} !== {16'h0, 4'h0, 1'b0, 16'd16}) begin
                errors++;
                $display("FAIL pause_hold: got %h want %h",
                         {bus.ir, pc, bus.exec_valid, retired}, {16'h0, 4'h0, 1'b0, 16'd16});
            end
        end
        run = 1'b1;
        step();
        step();
        checks++;
        if (bus.ir !== 16'h3456) begin
            errors++;
            $display("FAIL resume_fetch: got %h want %h", bus.ir, 16'h3456);
        end
        bus.exec_ready = 1'b1;
        step();
        step();
        bus.exec_ready = 1'b0;
        checks++;
        if ({pc, retired} !== {4'h1, 16'd17}) begin
            errors++;
            $display("FAIL resume_retire: got %h want %h", {pc, retired}, {4'h1, 16'd17});
        end
    endtask

    task automatic test_reset_in_exec();
        fill_nop();
        rom[1] = 16'hE512;
        do_reset();
        run = 1'b1;
        repeat (5) step();
        checks++;
        if ({bus.exec_valid, pc, retired} !== {1'b1, 4'h1, 16'h1}) begin
            errors++;
            $display("FAIL rx_enter: got %h want %h", {bus.exec_valid, pc, retired}, {1'b1, 4'h1, 16'h1});
        end
        rst = 1'b1;
        rom[0] = 16'h1A55;
        step();
        rst = 1'b0;
        checks++;
        if ({bus.exec_valid, pc, retired, bus.ir, halted} !== {1'b0, 4'h0, 16'h0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL rx_cleared: got %h want %h",
                     {bus.exec_valid, pc, retired, bus.ir, halted}, {1'b0, 4'h0, 16'h0, 16'h0, 1'b0});
        end
        step();
        checks++;
        if (bus.ir !== 16'h0) begin
            errors++;
            $display("FAIL rx_idle_first: got %h want %h", bus.ir, 16'h0);
        end
        step();
        checks++;
        if (bus.ir !== 16'h1A55) begin
            errors++;
            $display("FAIL rx_refetch: got %h want %h", bus.ir, 16'h1A55);
        end
    endtask

    task automatic test_random();
        int         m_pc;
        int         m_ret;
        int         waits;
        logic [15:0] inst;
        logic [3:0] op;
        logic [3:0] tgt;
        logic       z;
        logic       rdy;

        rand_rom();
        do_reset();
        run = 1'b1;
        step();
        m_pc  = 0;
        m_ret = 0;
        for (int n = 0; n < 300; n++) begin
            inst = rom[m_pc];
            op   = inst[15:12];
            tgt  = inst[11:8];
            bus.exec_ready = 1'($urandom);
            step();
            checks++;
            if ({bus.ir, bus.exec_valid, pc} !== {inst, 1'b0, 4'(m_pc)}) begin
                errors++;
                $display("FAIL rnd_fetch: got %h want %h", {bus.ir, bus.exec_valid, pc}, {inst, 1'b0, 4'(m_pc)});
            end
            z = 1'($urandom);
            bus.zero_flag  = z;
            bus.exec_ready = 1'($urandom);
            step();
            if (op == 4'h8 && int'(tgt) == m_pc) begin
                m_ret = sat_inc(m_ret);
                checks++;
                if ({halted, pc, retired, bus.exec_valid} !== {1'b1, 4'(m_pc), 16'(m_ret), 1'b0}) begin
                    errors++;
                    $display("FAIL rnd_halt: got %h want %h",
                             {halted, pc, retired, bus.exec_valid}, {1'b1, 4'(m_pc), 16'(m_ret), 1'b0});
                end
                rand_rom();
                do_reset();
                run = 1'b1;
                step();
                m_pc  = 0;
                m_ret = 0;
            end else if (op == 4'h8 || op == 4'hC || op == 4'h0) begin
                if (op == 4'h8 || (op == 4'hC && z)) m_pc = int'(tgt);
                else m_pc = (m_pc + 1) % 16;
                m_ret = sat_inc(m_ret);
                checks++;
                if ({pc, retired, bus.exec_valid, halted} !== {4'(m_pc), 16'(m_ret), 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL rnd_flow: got %h want %h",
                             {pc, retired, bus.exec_valid, halted}, {4'(m_pc), 16'(m_ret), 1'b0, 1'b0});
                end
            end else begin
                checks++;
                if ({bus.exec_valid, pc, bus.ir} !== {1'b1, 4'(m_pc), inst}) begin
                    errors++;
                    $display("FAIL rnd_issue: got %h want %h", {bus.exec_valid, pc, bus.ir}, {1'b1, 4'(m_pc), inst});
                end
                waits = 0;
                do begin
                    rdy = (waits == 4) ? 1'b1 : 1'($urandom);
                    bus.exec_ready = rdy;
                    step();
                    waits++;
                    if (rdy) begin
                        m_pc  = (m_pc + 1) % 16;
                        m_ret = sat_inc(m_ret);
                        checks++;
                        if ({bus.exec_valid, pc, retired} !== {1'b0, 4'(m_pc), 16'(m_ret)}) begin
                            errors++;
                            $display("FAIL rnd_complete: got %h want %h",
                                     {bus.exec_valid, pc, retired}, {1'b0, 4'(m_pc), 16'(m_ret)});
                        end
                    end else begin
                        checks++;
                        if ({bus.exec_valid, pc, bus.ir} !== {1'b1, 4'(m_pc), inst}) begin
                            errors++;
                            $display("FAIL rnd_stall: got %h want %h",
                                     {bus.exec_valid, pc, bus.ir}, {1'b1, 4'(m_pc), inst});
                        end
                    end
                end while (!rdy);
            end
        end
        bus.exec_ready = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        run            = 1'b0;
        bus.exec_ready = 1'b0;
        bus.zero_flag  = 1'b0;
        fill_nop();
        test_reset();
        test_first_fetch();
        test_halt();
        test_branch();
        test_backpressure();
        test_wrap_pause();
        test_reset_in_exec();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
